// File: rtl/priority_arbiter.sv
// priority_arbiter: N-way request arbiter with a registered grant and a
// valid/ready handshake. Fixed mode grants the highest pending index;
// rotating mode searches downward from a pointer that moves just below the
// requester served last, so every active requester is eventually served.
module priority_arbiter #(
    parameter int N           = 16,
    parameter int ROUND_ROBIN = 0,
    localparam int W          = (N == 1) ? 1 : $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] request,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] grant_id,
    output logic [N-1:0] grant_onehot
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);
    localparam logic [W-1:0] IDX_ONE  = W'(1);

    state_t         state_r;
    state_t         state_s;
    logic           valid_r;
    logic           valid_s;
    logic [W-1:0]   grant_id_r;
    logic [W-1:0]   grant_id_s;
    logic [N-1:0]   onehot_r;
    logic [N-1:0]   onehot_s;
    logic [W-1:0]   ptr_r;
    logic [W-1:0]   ptr_s;
    logic [W-1:0]   ptr_after_s;
    logic [W-1:0]   start_s;
    logic [W-1:0]   win_s;
    logic [N-1:0]   win_onehot_s;

    // Winner search. Rotating: first set bit walking down from start,
    // wrapping N-1 after 0. Fixed: highest set index. Result is always < N.
    function automatic logic [W-1:0] pick_winner(input logic [N-1:0] req,
                                                 input logic [W-1:0] start);
        logic [W-1:0] win;
        logic         found;
        int           s;
        int           idx;
        win   = {W{1'b0}};
        found = 1'b0;
        s     = int'(start);
        if (ROUND_ROBIN != 0) begin
            for (int k = 0; k < N; k++) begin
                idx   = (s - k + N) % N;
                win   = (!found && req[idx]) ? W'(idx) : win;
                found = found | req[idx];
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                win = req[i] ? W'(i) : win;
            end
        end
        return win;
    endfunction

    // Pointer value after serving the current grant: one below it, wrapping.
    always_comb begin
        ptr_after_s = ptr_r;
        if (grant_id_r == {W{1'b0}}) begin
            ptr_after_s = LAST_IDX;
        end else begin
            ptr_after_s = grant_id_r - IDX_ONE;
        end
    end

    // Arbitration: a back-to-back decision must already see the moved pointer.
    always_comb begin
        start_s      = (state_r == ST_GRANT) ? ptr_after_s : ptr_r;
        win_s        = pick_winner(request, start_s);
        win_onehot_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            win_onehot_s[i] = (win_s == W'(i));
        end
    end

    // Next-state and next-output logic; grant fields hold unless a new
    // winner is loaded, so a stalled grant is immune to request changes.
    always_comb begin
        state_s    = state_r;
        valid_s    = valid_r;
        grant_id_s = grant_id_r;
        onehot_s   = onehot_r;
        ptr_s      = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (request != {N{1'b0}}) begin
                    state_s    = ST_GRANT;
                    valid_s    = 1'b1;
                    grant_id_s = win_s;
                    onehot_s   = win_onehot_s;
                end else begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (ready) begin
                    if (ROUND_ROBIN != 0) begin
                        ptr_s = ptr_after_s;
                    end else begin
                        ptr_s = ptr_r;
                    end
                    if (request != {N{1'b0}}) begin
                        grant_id_s = win_s;
                        onehot_s   = win_onehot_s;
                    end else begin
                        state_s  = ST_IDLE;
                        valid_s  = 1'b0;
                        onehot_s = {N{1'b0}};
                    end
                end else begin
                    state_s = ST_GRANT;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                valid_s  = 1'b0;
                onehot_s = {N{1'b0}};
            end
        endcase
    end

    // State, pointer and output registers; reset makes the first rotating
    // decision identical to fixed priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            valid_r    <= 1'b0;
            grant_id_r <= {W{1'b0}};
            onehot_r   <= {N{1'b0}};
            ptr_r      <= LAST_IDX;
        end else begin
            state_r    <= state_s;
            valid_r    <= valid_s;
            grant_id_r <= grant_id_s;
            onehot_r   <= onehot_s;
            ptr_r      <= ptr_s;
        end
    end

    assign valid        = valid_r;
    assign grant_id     = grant_id_r;
    assign grant_onehot = onehot_r;

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter N, default 16: number of requesters; N >= 1.
REQ-002 Parameter ROUND_ROBIN, default 0: 0 = fixed priority, 1 = rotating priority.
REQ-003 Derived width W = 1 when N == 1, else $clog2(N).
REQ-004 clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 request  input  N  request vector; bit i = requester i pending.
REQ-007 ready  input  1  consumer accepts the current grant this cycle.
REQ-008 valid  output  1  a grant is being presented.
REQ-009 grant_id  output  W  encoded index of the granted requester.
REQ-010 grant_onehot  output  N  one-hot form of grant_id when valid = 1; all-zero when valid = 0.

Function
REQ-011 The block SHALL implement two states: IDLE (valid = 0) and GRANT (valid = 1).
REQ-012 Winner selection, fixed mode: the highest set index of request wins, i.e. index = floor(log2(request)).
REQ-013 Winner selection, rotating mode: search starts at index ptr and descends, wrapping from 0 to N-1; the first set bit wins.
REQ-014 The pointer ptr (W bits) SHALL be used only when ROUND_ROBIN = 1.
REQ-015 IDLE -> GRANT: when request != 0 at a rising edge, the winner is registered into grant_id and valid = 1 from the next cycle (1-cycle latency).
REQ-016 IDLE with request == 0: the block SHALL stay in IDLE and grant_id SHALL hold its previous value.
REQ-017 Holding a grant: in GRANT with ready = 0, valid, grant_id and grant_onehot SHALL hold stable, even if request changes or the granted bit drops.
REQ-018 Handshake: a transfer occurs on a rising edge where valid = 1 and ready = 1.
REQ-019 Pointer update on transfer, rotating mode: ptr <= grant_id - 1, wrapping 0 to N-1, so the served requester becomes lowest priority.
REQ-020 Back-to-back: on a transfer edge, the block SHALL arbitrate on the current request.
REQ-021 Back-to-back arbitration SHALL use the updated pointer; if request != 0 it stays in GRANT with the new winner, with no bubble.
REQ-022 End of grant: on a transfer edge with request == 0, the block SHALL go to IDLE.
REQ-023 ready while valid = 0 SHALL be ignored.
REQ-024 Degenerate case N = 1: grant_id is constantly 0 and the block reduces to a request/valid handshake.
REQ-025 Winner indices are always < N; a non-power-of-two N SHALL never yield an out-of-range grant_id.

Reset
REQ-026 Asserting reset SHALL immediately clear all outputs, independent of clock: valid = 0, grant_id = 0, grant_onehot = 0.
REQ-027 Asserting reset SHALL set state = IDLE and ptr = N-1, so the first rotating arbitration equals fixed priority.
REQ-028 Reset asserted mid-grant SHALL abort the grant with no transfer; after release, arbitration restarts from IDLE.
REQ-029 Deassertion of reset is synchronous to clock by the surrounding design; the block needs no internal synchroniser.

Verification (N = 4 unless stated)
REQ-030 Exhaustive fixed mode, N = 16:
- For every request value 1..65535, present it from IDLE with ready = 1.
- Required: grant_id = floor(log2(request)) one cycle later.
- Required: grant_onehot = 1 << grant_id.
REQ-031 Hold test:
- request = 4'b0110, ready = 0 for 5 cycles, then request = 4'b0001.
- Required: grant_id stays 2 and valid stays 1 throughout.
REQ-032 Rotating fairness:
- ROUND_ROBIN = 1, request = 4'b1111, ready = 1 constant.
- Required grant_id sequence: 3, 2, 1, 0, 3, with valid continuously 1.
REQ-033 Rotating skip:
- ROUND_ROBIN = 1, request = 4'b1010, ready = 1.
- Required grant sequence: 3, 1, 3, 1.
REQ-034 Drain to idle:
- Single request 4'b0100, accepted, then request = 0.
- Required: valid = 0 on the cycle after the transfer, with grant_id holding 2.
REQ-035 Reset mid-grant:
- Assert reset while valid = 1 and ready = 0.
- Required: valid = 0 and grant_id = 0 immediately.
- Required: after release with request = 4'b1111, the first grant_id = 3.
